// File: rtl/fp16_vec_accumulator_if.sv
// Stream bundle between the PE product stage, the FP16 vector accumulator and writeback.
// master drives elements and accepts sums; slave is the accumulator.
interface fp16_vec_accumulator_if #(
   parameter int MAX_LEN = 16
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);

   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic [CNT_W-1:0] out_len;
   logic             out_trunc;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output clear,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_len,
      input  out_trunc
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  clear,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_len,
      output out_trunc
   );
endinterface

// File: rtl/fp16_vec_accumulator.sv
// Streaming FP16 vector reduction: sums one element per beat into a registered accumulator
// and holds the finished sum on a valid/ready output until writeback takes it.

module fp16adder (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_sum
);
   logic        w_aBig;
   logic [15:0] w_big;
   logic [15:0] w_small;
   logic [4:0]  w_expDiff;
   logic [10:0] w_manBig;
   logic [10:0] w_manSmall;
   logic [10:0] w_manShift;
   logic [11:0] w_manSum;
   logic [10:0] w_manDiff;
   logic [3:0]  w_lz;
   logic [10:0] w_manNorm;

   // Exponent 0 is treated as zero; the smaller operand is aligned by truncating shift.
   always_comb begin
      w_aBig     = (i_a[14:0] >= i_b[14:0]);
      w_big      = w_aBig ? i_a : i_b;
      w_small    = w_aBig ? i_b : i_a;
      w_expDiff  = w_big[14:10] - w_small[14:10];
      w_manBig   = {1'b1, w_big[9:0]};
      w_manSmall = {1'b1, w_small[9:0]};
      w_manShift = (w_expDiff > 5'd10) ? 11'd0 : (w_manSmall >> w_expDiff);
      w_manSum   = {1'b0, w_manBig} + {1'b0, w_manShift};
      w_manDiff  = w_manBig - w_manShift;
      w_lz       = 4'd0;
      for (int i = 0; i < 11; i++) begin
         if (w_manDiff[i]) begin
            w_lz = 4'(10 - i);
         end
      end
      w_manNorm = w_manDiff << w_lz;
      o_sum     = 16'h0000;
      if (i_a[14:10] == 5'd0) begin
         o_sum = i_b;
      end else if (i_b[14:10] == 5'd0) begin
         o_sum = i_a;
      end else if (i_a[15] == i_b[15]) begin
         if (w_manSum[11]) begin
            o_sum = {w_big[15], w_big[14:10] + 5'd1, w_manSum[10:1]};
         end else begin
            o_sum = {w_big[15], w_big[14:10], w_manSum[9:0]};
         end
      end else if ((w_manDiff == 11'd0) || ({1'b0, w_big[14:10]} <= {2'b00, w_lz})) begin
         o_sum = 16'h0000;
      end else begin
         o_sum = {w_big[15], w_big[14:10] - {1'b0, w_lz}, w_manNorm[9:0]};
      end
   end
endmodule

module fp16_vec_accumulator #(
   parameter int MAX_LEN = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   fp16_vec_accumulator_if.slave       io_bus
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);

   typedef enum logic {
      ACC,
      HOLD
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [15:0]      r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_outData;
   logic [CNT_W-1:0] r_outLen;
   logic             r_outTrunc;
   logic [15:0]      w_sum;
   logic             w_inReady;
   logic             w_outValid;
   logic             w_beat;
   logic             w_take;
   logic             w_endVec;

   fp16adder u_adder (
      .i_a   (r_acc),
      .i_b   (io_bus.in_data),
      .o_sum (w_sum)
   );

   assign w_beat   = io_bus.in_valid & w_inReady;
   assign w_take   = w_beat & ~io_bus.clear;
   assign w_endVec = io_bus.in_last | (r_cnt == CNT_W'(MAX_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACC;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      w_outValid  = 1'b0;
      case (r_state)
         ACC: begin
            w_inReady = ~rst;
            if (w_take && w_endVec) begin
               w_nextState = HOLD;
            end
         end
         HOLD: begin
            w_outValid = 1'b1;
            if (io_bus.out_ready) begin
               w_nextState = ACC;
            end
         end
         default: w_nextState = ACC;
      endcase
   end

   // A clear in ACC wins over a same-cycle beat, which is silently dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= 16'h0000;
         r_cnt      <= '0;
         r_outData  <= 16'h0000;
         r_outLen   <= '0;
         r_outTrunc <= 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               if (io_bus.clear) begin
                  r_acc <= 16'h0000;
                  r_cnt <= '0;
               end else if (w_beat) begin
                  r_acc <= w_sum;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_endVec) begin
                     r_outData  <= w_sum;
                     r_outLen   <= r_cnt + CNT_W'(1);
                     r_outTrunc <= ~io_bus.in_last;
                  end
               end
            end
            HOLD: begin
               if (io_bus.out_ready) begin
                  r_acc <= 16'h0000;
                  r_cnt <= '0;
               end
            end
            default: begin
               r_acc <= 16'h0000;
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = w_inReady;
   assign io_bus.out_valid = w_outValid;
   assign io_bus.out_data  = r_outData;
   assign io_bus.out_len   = r_outLen;
   assign io_bus.out_trunc = r_outTrunc;
endmodule
